// File: rtl/seq_pkg.sv
// Shared types and default constants for the phrase sequencer.
// Holds the FSM state encoding and default table addresses.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam int DEF_TICK_DIV   = 4;
    localparam int DEF_STEPS      = 16;
    localparam int DEF_FIRST_ADDR = 1;
    localparam int DEF_LAST_ADDR  = 152;
    localparam int DEF_LOOP_ADDR  = 17;

endpackage

// File: rtl/step_timer.sv
// Tick divider plus step counter for the phrase sequencer.
// Ports: clk, rst (sync, active high), en (advance), clr (restart at 0),
//        step (current step), tick_wrap / step_wrap (step / phrase event).
module step_timer #(
    parameter int TICK_DIV = 4,
    parameter int STEPS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] step,
    output logic       tick_wrap,
    output logic       step_wrap
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  STEP_LAST = 4'(STEPS - 1);

    logic [15:0] tick;

    // Events are qualified by en so a frozen timer never fires.
    assign tick_wrap = en && (tick == TICK_LAST);
    assign step_wrap = tick_wrap && (step == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick <= '0;
            step <= '0;
        end else if (tick_wrap) begin
            tick <= '0;
            step <= step_wrap ? 4'd0 : step + 4'd1;
        end else if (en) begin
            tick <= tick + 16'd1;
        end
    end

endmodule

// File: rtl/phrase_sequencer.sv
// Walks a phrase-ID table, emitting step and phrase strobes.
// Ports: clk, rst, start, pause, loop_en in; rom_addr/db_entry table
//        lookup; phrase_id, step, step_strobe, phrase_strobe,
//        playing, done out.
module phrase_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV         = DEF_TICK_DIV,
    parameter int STEPS_PER_PHRASE = DEF_STEPS,
    parameter int FIRST_ADDR       = DEF_FIRST_ADDR,
    parameter int LAST_ADDR        = DEF_LAST_ADDR,
    parameter int LOOP_ADDR        = DEF_LOOP_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       loop_en,
    output logic [7:0] rom_addr,
    input  logic [4:0] db_entry,
    output logic [4:0] phrase_id,
    output logic [3:0] step,
    output logic       step_strobe,
    output logic       phrase_strobe,
    output logic       playing,
    output logic       done
);

    localparam logic [7:0] A_FIRST = 8'(FIRST_ADDR);
    localparam logic [7:0] A_LAST  = 8'(LAST_ADDR);
    localparam logic [7:0] A_LOOP  = 8'(LOOP_ADDR);

    state_t state_q, state_d;
    logic   load_q;
    logic   go, run, at_last;
    logic   tick_wrap, step_wrap;

    assign go      = (state_q == S_IDLE || state_q == S_DONE) && start;
    assign run     = (state_q == S_PLAY) && !pause;
    assign at_last = (rom_addr == A_LAST);
    assign playing = (state_q == S_PLAY) || (state_q == S_PAUSED);
    assign done    = (state_q == S_DONE);

    step_timer #(
        .TICK_DIV (TICK_DIV),
        .STEPS    (STEPS_PER_PHRASE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (run),
        .clr       (go),
        .step      (step),
        .tick_wrap (tick_wrap),
        .step_wrap (step_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (pause)
                    state_d = S_PAUSED;
                else if (step_wrap && at_last && !loop_en)
                    state_d = S_DONE;
            end
            S_PAUSED: begin
                if (!pause) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // load_q marks that rom_addr just moved and db_entry must be
    // captured on the next running cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr      <= '0;
            phrase_id     <= '0;
            load_q        <= 1'b0;
            step_strobe   <= 1'b0;
            phrase_strobe <= 1'b0;
        end else begin
            step_strobe   <= 1'b0;
            phrase_strobe <= 1'b0;
            if (go) begin
                rom_addr <= A_FIRST;
                load_q   <= 1'b1;
            end else if (run) begin
                if (load_q) begin
                    phrase_id     <= db_entry;
                    phrase_strobe <= 1'b1;
                    step_strobe   <= 1'b1;
                    load_q        <= 1'b0;
                end
                if (step_wrap) begin
                    if (!at_last) begin
                        rom_addr <= rom_addr + 8'd1;
                        load_q   <= 1'b1;
                    end else if (loop_en) begin
                        rom_addr <= A_LOOP;
                        load_q   <= 1'b1;
                    end else begin
                        phrase_id <= '0;
                    end
                end else if (tick_wrap) begin
                    step_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Scoreboard bench for phrase_sequencer with random pauses.
// Expected strobes come from a phrase/step timeline model.
module tb_phrase_sequencer;

    localparam int TD    = 4;
    localparam int SPP   = 16;
    localparam int FIRST = 1;
    localparam int LAST  = 3;
    localparam int LOOPA = 2;
    localparam int PLEN  = TD * SPP;

    typedef struct {
        int         r;
        bit         ph;
        logic [4:0] pid;
        logic [7:0] addr;
        logic [3:0] stp;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, start, pause, loop_en;
    logic [7:0] rom_addr;
    logic [4:0] db_entry, phrase_id;
    logic [3:0] step;
    logic       step_strobe, phrase_strobe, playing, done;

    ev_t q[$];
    int  nchk = 0;
    int  npass = 0;
    int  r = 0;
    bit  active = 0;
    bit  arm = 0;
    bit  pm = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] tbl(logic [7:0] a);
        logic [7:0] t;
        t = a + 8'd18;
        return t[4:0];
    endfunction

    assign db_entry = tbl(rom_addr);

    phrase_sequencer #(
        .TICK_DIV         (TD),
        .STEPS_PER_PHRASE (SPP),
        .FIRST_ADDR       (FIRST),
        .LAST_ADDR        (LAST),
        .LOOP_ADDR        (LOOPA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pause         (pause),
        .loop_en       (loop_en),
        .rom_addr      (rom_addr),
        .db_entry      (db_entry),
        .phrase_id     (phrase_id),
        .step          (step),
        .step_strobe   (step_strobe),
        .phrase_strobe (phrase_strobe),
        .playing       (playing),
        .done          (done)
    );

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    // Timeline model: r counts running cycles since start.
    // A pause costs its own cycles plus one cycle to resume.
    always @(posedge clk) begin
        if (arm) begin
            arm    = 0;
            active = 1;
            pm     = 0;
            r      = 0;
        end else if (active) begin
            if (pm) begin
                if (!pause) pm = 0;
            end else if (pause) begin
                pm = 1;
            end else begin
                r++;
            end
        end
    end

    // Phrase p starts at r = p*PLEN+1, step s lands at r = p*PLEN+TD*s.
    task automatic push_phrases(int n, bit lp);
        int a;
        ev_t e;
        a = FIRST;
        for (int p = 0; p < n; p++) begin
            e.r    = p * PLEN + 1;
            e.ph   = 1;
            e.pid  = tbl(8'(a));
            e.addr = 8'(a);
            e.stp  = 0;
            q.push_back(e);
            for (int s = 1; s < SPP; s++) begin
                e.r   = p * PLEN + TD * s;
                e.ph  = 0;
                e.stp = 4'(s);
                q.push_back(e);
            end
            if (a < LAST) a = a + 1;
            else if (lp) a = LOOPA;
            else break;
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (phrase_strobe || step_strobe) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe",
                    {phrase_strobe, step_strobe}, 2'b00);
            end else begin
                e = q.pop_front();
                chk("strobe_event",
                    {16'(r), phrase_strobe, step_strobe,
                     phrase_id, rom_addr, step},
                    {16'(e.r), e.ph, 1'b1, e.pid, e.addr, e.stp});
            end
        end
    end

    task automatic do_reset();
        rst    = 1;
        active = 0;
        @(negedge clk);
        q.delete();
        pause = 0;
        chk("rst_outs",
            {rom_addr, phrase_id, step, step_strobe,
             phrase_strobe, playing, done}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_release",
            {step_strobe, phrase_strobe, playing, rom_addr}, 0);
    endtask

    task automatic go();
        start = 1;
        arm   = 1;
        @(negedge clk);
        start = 0;
        chk("go_state", {rom_addr, step, playing, done},
            {8'(FIRST), 4'd0, 1'b1, 1'b0});
    endtask

    task automatic run_rand(int n);
        int plen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pause) begin
                plen--;
                if (plen <= 0) pause = 0;
            end else if ($urandom_range(0, 15) == 0) begin
                pause = 1;
                plen  = $urandom_range(1, 12);
            end
        end
        pause = 0;
    endtask

    task automatic drain(int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 0);
    endtask

    task automatic wait_step(logic [3:0] s);
        int n = 0;
        while (step != s && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_step", step, s);
    endtask

    initial begin
        logic [3:0] s0;
        logic [7:0] a0;
        int n;
        rst = 1;
        start = 0;
        pause = 0;
        loop_en = 1;
        repeat (3) @(negedge clk);
        do_reset();

        // Looping playback with random pauses and one paused event.
        repeat ($urandom_range(1, 5)) @(negedge clk);
        push_phrases(8, 1);
        go();
        run_rand(150);
        n = 0;
        while (!(step_strobe && !phrase_strobe) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("find_step", {step_strobe, phrase_strobe}, 2'b10);
        repeat (TD - 1) @(negedge clk);
        pause = 1;
        s0 = step;
        a0 = rom_addr;
        repeat (10) @(negedge clk);
        chk("pause_hold", {step, rom_addr, playing}, {s0, a0, 1'b1});
        pause = 0;
        @(negedge clk);
        chk("resume_wait", step, s0);
        @(negedge clk);
        chk("resume_fire", 64'(step != s0), 1);
        drain(2000);
        do_reset();

        // Stop at end of table, then restart from DONE.
        loop_en = 0;
        push_phrases(3, 0);
        go();
        run_rand(100);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done_r", 64'(r), 3 * PLEN);
        chk("done_outs", {done, playing, phrase_id, step},
            {1'b1, 1'b0, 5'd0, 4'd0});
        chk("done_q", 64'(q.size()), 0);
        pause = 1;
        repeat (8) @(negedge clk);
        pause = 0;
        chk("done_hold", {done, playing}, 2'b10);
        push_phrases(1, 0);
        go();
        wait_step(4'd7);
        do_reset();

        // Restart after reset, then reset while paused.
        push_phrases(1, 0);
        go();
        wait_step(4'd3);
        pause = 1;
        repeat (3) @(negedge clk);
        chk("paused_play", {playing, step}, {1'b1, 4'd3});
        do_reset();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
